// File: rtl/nn_io_sequencer.sv
// Frame sequencer: gathers N_IN samples, runs the layer chain via a four-phase
// req/ack handshake, captures N_OUT results and streams them out (valid/ready).
module nn_io_sequencer #(
  parameter int DATA_W = 8,
  parameter int N_IN   = 8,
  parameter int N_OUT  = 8,
  parameter int CNT_W  = 16,
  localparam int IAW   = $clog2(N_IN),
  localparam int OAW   = $clog2(N_OUT)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    fill_valid,
  input  logic [DATA_W-1:0]       fill_data,
  output logic                    fill_ready,
  output logic                    net_req,
  input  logic                    net_ack,
  input  logic [IAW-1:0]          in_rd_addr,
  output logic [DATA_W-1:0]       in_rd_data,
  input  logic [N_OUT*DATA_W-1:0] res_bus,
  output logic [N_OUT*DATA_W-1:0] out_vec,
  output logic                    out_valid,
  output logic [DATA_W-1:0]       out_data,
  input  logic                    out_ready,
  output logic                    frame_done,
  output logic [CNT_W-1:0]        frame_count,
  output logic                    busy,
  output logic [1:0]              state_dbg
);

  // Stream handshake: a beat transfers on every rising edge where
  // out_valid & out_ready are both high; out_data is stable while stalled.
  typedef enum logic [1:0] {
    S_FILL    = 2'd0,
    S_WAITLOW = 2'd1,
    S_RUN     = 2'd2,
    S_DRAIN   = 2'd3
  } state_e;

  localparam logic [IAW-1:0] WP_LAST  = IAW'(N_IN - 1);
  localparam logic [OAW-1:0] RP_LAST  = OAW'(N_OUT - 1);
  localparam logic [IAW:0]   RD_LIMIT = (IAW + 1)'(N_IN);

  state_e                  state_q, state_d;
  logic [IAW-1:0]          wp_q, wp_d;
  logic [OAW-1:0]          rp_q, rp_d;
  logic                    net_req_q, net_req_d;
  logic                    out_valid_q, out_valid_d;
  logic                    frame_done_q, frame_done_d;
  logic [CNT_W-1:0]        frame_count_q, frame_count_d;
  logic [DATA_W-1:0]       in_rd_data_q, in_rd_data_d;
  logic [N_OUT*DATA_W-1:0] out_vec_q, out_vec_d;
  logic [DATA_W-1:0]       mem_q [N_IN];
  logic [DATA_W-1:0]       mem_d [N_IN];

  always_comb begin
    state_d       = state_q;
    wp_d          = wp_q;
    rp_d          = rp_q;
    net_req_d     = net_req_q;
    out_valid_d   = out_valid_q;
    frame_done_d  = 1'b0;
    frame_count_d = frame_count_q;
    out_vec_d     = out_vec_q;
    mem_d         = mem_q;

    // Reads see the pre-write contents; addresses past N_IN-1 read as zero.
    in_rd_data_d = '0;
    if ({1'b0, in_rd_addr} < RD_LIMIT) in_rd_data_d = mem_q[in_rd_addr];

    if (clr) begin
      state_d     = S_FILL;
      wp_d        = '0;
      rp_d        = '0;
      net_req_d   = 1'b0;
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        S_FILL: begin
          if (fill_valid) begin
            mem_d[wp_q] = fill_data;
            if (wp_q == WP_LAST) begin
              wp_d    = '0;
              state_d = net_ack ? S_WAITLOW : S_RUN;
            end else begin
              wp_d = wp_q + 1'b1;
            end
          end
        end
        S_WAITLOW: begin
          if (!net_ack) state_d = S_RUN;
        end
        S_RUN: begin
          // An ack seen before our request is up belongs to nobody and is ignored.
          if (!net_req_q) begin
            net_req_d = 1'b1;
          end else if (net_ack) begin
            out_vec_d   = res_bus;
            net_req_d   = 1'b0;
            rp_d        = '0;
            out_valid_d = 1'b1;
            state_d     = S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (out_valid_q && out_ready) begin
            if (rp_q == RP_LAST) begin
              rp_d          = '0;
              out_valid_d   = 1'b0;
              frame_done_d  = 1'b1;
              frame_count_d = frame_count_q + 1'b1;
              state_d       = S_FILL;
            end else begin
              rp_d = rp_q + 1'b1;
            end
          end
        end
        default: state_d = S_FILL;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_FILL;
      wp_q          <= '0;
      rp_q          <= '0;
      net_req_q     <= 1'b0;
      out_valid_q   <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_count_q <= '0;
      in_rd_data_q  <= '0;
      out_vec_q     <= '0;
      for (int i = 0; i < N_IN; i++) mem_q[i] <= '0;
    end else begin
      state_q       <= state_d;
      wp_q          <= wp_d;
      rp_q          <= rp_d;
      net_req_q     <= net_req_d;
      out_valid_q   <= out_valid_d;
      frame_done_q  <= frame_done_d;
      frame_count_q <= frame_count_d;
      in_rd_data_q  <= in_rd_data_d;
      out_vec_q     <= out_vec_d;
      for (int i = 0; i < N_IN; i++) mem_q[i] <= mem_d[i];
    end
  end

  always_comb begin
    out_data = '0;
    for (int k = 0; k < N_OUT; k++) begin
      if (rp_q == OAW'(k)) out_data = out_vec_q[k*DATA_W +: DATA_W];
    end
  end

  assign fill_ready  = (state_q == S_FILL);
  assign busy        = (state_q != S_FILL);
  assign net_req     = net_req_q;
  assign out_valid   = out_valid_q;
  assign frame_done  = frame_done_q;
  assign frame_count = frame_count_q;
  assign in_rd_data  = in_rd_data_q;
  assign out_vec     = out_vec_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_nn_io_sequencer.sv
// Bench for nn_io_sequencer: an 8/8 instance driven through the main scenarios
// plus a 5-in/3-out/12-bit/2-bit-counter instance for the parameter sweep.
module tb_nn_io_sequencer;

  localparam logic [1:0] ST_FILL    = 2'd0;
  localparam logic [1:0] ST_WAITLOW = 2'd1;
  localparam logic [1:0] ST_RUN     = 2'd2;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  int checks   = 0;
  int failures = 0;

  // ---------------- instance A: 8 in / 8 out / 8 bit / 16 bit counter
  logic        a_clr, a_fill_valid, a_fill_ready, a_net_req, a_net_ack;
  logic [7:0]  a_fill_data, a_rd_data, a_out_data;
  logic [2:0]  a_rd_addr;
  logic [63:0] a_res_bus, a_out_vec;
  logic        a_out_valid, a_out_ready, a_frame_done, a_busy;
  logic [15:0] a_frame_count;
  logic [1:0]  a_state;

  nn_io_sequencer #(.DATA_W(8), .N_IN(8), .N_OUT(8), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .clr(a_clr),
    .fill_valid(a_fill_valid), .fill_data(a_fill_data), .fill_ready(a_fill_ready),
    .net_req(a_net_req), .net_ack(a_net_ack),
    .in_rd_addr(a_rd_addr), .in_rd_data(a_rd_data),
    .res_bus(a_res_bus), .out_vec(a_out_vec),
    .out_valid(a_out_valid), .out_data(a_out_data), .out_ready(a_out_ready),
    .frame_done(a_frame_done), .frame_count(a_frame_count),
    .busy(a_busy), .state_dbg(a_state)
  );

  // ---------------- instance B: 5 in / 3 out / 12 bit / 2 bit counter
  logic        b_clr, b_fill_valid, b_fill_ready, b_net_req, b_net_ack;
  logic [11:0] b_fill_data, b_rd_data, b_out_data;
  logic [2:0]  b_rd_addr;
  logic [35:0] b_res_bus, b_out_vec;
  logic        b_out_valid, b_out_ready, b_frame_done, b_busy;
  logic [1:0]  b_frame_count;
  logic [1:0]  b_state;

  nn_io_sequencer #(.DATA_W(12), .N_IN(5), .N_OUT(3), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .clr(b_clr),
    .fill_valid(b_fill_valid), .fill_data(b_fill_data), .fill_ready(b_fill_ready),
    .net_req(b_net_req), .net_ack(b_net_ack),
    .in_rd_addr(b_rd_addr), .in_rd_data(b_rd_data),
    .res_bus(b_res_bus), .out_vec(b_out_vec),
    .out_valid(b_out_valid), .out_data(b_out_data), .out_ready(b_out_ready),
    .frame_done(b_frame_done), .frame_count(b_frame_count),
    .busy(b_busy), .state_dbg(b_state)
  );

  // ---------------- reference model state
  logic [7:0]  a_sent [8];
  logic [63:0] a_exp_vec;
  int          a_exp_count;
  int          a_done_cnt = 0;
  logic [7:0]  a_got [$];
  logic [7:0]  a_stall [$];

  always @(negedge clk) if (a_frame_done === 1'b1) a_done_cnt++;

  // Stub network function: result k = input[k mod 8] + k + 1 (8-bit wrap).
  function automatic logic [63:0] a_model_vec();
    logic [63:0] v;
    for (int k = 0; k < 8; k++) v[k*8 +: 8] = a_sent[k % 8] + 8'(k + 1);
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- drivers
  task automatic a_fill(input bit toggle);
    for (int i = 0; i < 8; i++) begin
      if (toggle) begin
        a_fill_valid = 1'b0;
        step();
      end
      a_fill_valid = 1'b1;
      a_fill_data  = a_sent[i];
      step();
    end
    a_fill_valid = 1'b0;
  endtask

  // Stub layer chain: waits for net_req, optionally reads the input buffer
  // through the read port, waits lat cycles, then acks for one edge.
  task automatic a_serve(input int lat, input bit keep_ack, input bit use_fixed,
                         input logic [63:0] fixed);
    int guard = 0;
    logic [7:0] rd [8];
    while (a_net_req !== 1'b1 && guard < 100) begin
      step();
      guard++;
    end
    checks++;
    if (a_net_req !== 1'b1) begin
      failures++;
      $display("FAIL serve_wait_req net_req=%b required=1", a_net_req);
      return;
    end
    if (use_fixed) begin
      a_res_bus = fixed;
    end else begin
      for (int i = 0; i < 8; i++) begin
        a_rd_addr = 3'(i);
        step();
        rd[i] = a_rd_data;
      end
      for (int k = 0; k < 8; k++) a_res_bus[k*8 +: 8] = rd[k % 8] + 8'(k + 1);
    end
    repeat (lat) step();
    a_net_ack = 1'b1;
    step();
    if (!keep_ack) a_net_ack = 1'b0;
  endtask

  task automatic a_drain(input int n, input int stall_at, input int stall_len);
    int beats = 0, stalled = 0, guard = 0;
    a_got.delete();
    a_stall.delete();
    while (beats < n && guard < 200) begin
      guard++;
      if (beats == stall_at && stalled < stall_len) begin
        a_out_ready = 1'b0;
        if (a_out_valid) a_stall.push_back(a_out_data);
        stalled++;
      end else begin
        a_out_ready = 1'b1;
        if (a_out_valid) begin
          a_got.push_back(a_out_data);
          beats++;
        end
      end
      step();
    end
    a_out_ready = 1'b0;
  endtask

  // ---------------- tests
  task automatic test_reset();
    rst = 1'b0;
    #3;
    checks++;
    if ({a_fill_ready, a_busy, a_net_req, a_out_valid, a_frame_done} !== 5'b10000 ||
        a_frame_count !== 16'd0 || a_out_vec !== 64'd0 || a_rd_data !== 8'd0) begin
      failures++;
      $display("FAIL reset_outputs rdy/busy/req/val/done=%b cnt=%0d vec=%h rd=%h required=10000/0/0/0",
               {a_fill_ready, a_busy, a_net_req, a_out_valid, a_frame_done},
               a_frame_count, a_out_vec, a_rd_data);
    end
    repeat (3) step();
    rst = 1'b1;
    step();
    checks++;
    if (a_state !== ST_FILL || a_fill_ready !== 1'b1 || b_fill_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release state=%0d a_rdy=%b b_rdy=%b required=0/1/1",
               a_state, a_fill_ready, b_fill_ready);
    end
    a_exp_count = 0;
    a_exp_vec   = '0;
  endtask

  task automatic test_basic();
    logic [63:0] fixed;
    int done_before;
    logic [7:0] e;
    for (int i = 0; i < 8; i++) a_sent[i] = 8'(i + 1);
    for (int k = 0; k < 8; k++) fixed[k*8 +: 8] = (k % 2 == 0) ? -8'(k + 1) : 8'(k + 1);
    done_before = a_done_cnt;
    a_fill(1'b0);
    a_serve(3, 1'b0, 1'b1, fixed);
    a_exp_vec = fixed;
    checks++;
    if (a_net_req !== 1'b0 || a_out_valid !== 1'b1 || a_out_vec !== fixed) begin
      failures++;
      $display("FAIL basic_capture req=%b val=%b vec=%h required=0/1/%h",
               a_net_req, a_out_valid, a_out_vec, fixed);
    end
    a_drain(8, -1, 0);
    for (int k = 0; k < 8; k++) begin
      e = fixed[k*8 +: 8];
      checks++;
      if (a_got.size() <= k || a_got[k] !== e) begin
        failures++;
        $display("FAIL basic_beat%0d got=%h required=%h", k, (a_got.size() > k) ? a_got[k] : 8'hxx, e);
      end
    end
    a_exp_count++;
    checks++;
    if (a_frame_done !== 1'b1 || a_fill_ready !== 1'b1) begin
      failures++;
      $display("FAIL basic_done_cycle done=%b rdy=%b required=1/1", a_frame_done, a_fill_ready);
    end
    a_rd_addr = 3'd4;
    step();
    checks++;
    if (a_frame_done !== 1'b0 || (a_done_cnt - done_before) != 1 ||
        a_frame_count !== 16'(a_exp_count)) begin
      failures++;
      $display("FAIL basic_count done=%b pulses=%0d cnt=%0d required=0/1/%0d",
               a_frame_done, a_done_cnt - done_before, a_frame_count, a_exp_count);
    end
    checks++;
    if (a_rd_data !== 8'd5) begin
      failures++;
      $display("FAIL basic_rd_addr4 got=%0d required=5", a_rd_data);
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] v;
    for (int i = 0; i < 8; i++) a_sent[i] = 8'($urandom);
    v = a_model_vec();
    a_fill(1'b1);
    a_serve($urandom_range(0, 4), 1'b0, 1'b0, '0);
    a_exp_vec = v;
    a_drain(8, 3, 5);
    a_exp_count++;
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (a_got.size() <= k || a_got[k] !== v[k*8 +: 8]) begin
        failures++;
        $display("FAIL bp_beat%0d got=%h required=%h", k, (a_got.size() > k) ? a_got[k] : 8'hxx, v[k*8 +: 8]);
      end
    end
    checks++;
    if (a_stall.size() != 5) begin
      failures++;
      $display("FAIL bp_stall_len got=%0d required=5", a_stall.size());
    end
    foreach (a_stall[j]) begin
      checks++;
      if (a_stall[j] !== v[3*8 +: 8]) begin
        failures++;
        $display("FAIL bp_stall_hold%0d got=%h required=%h", j, a_stall[j], v[3*8 +: 8]);
      end
    end
    checks++;
    if (a_frame_count !== 16'(a_exp_count)) begin
      failures++;
      $display("FAIL bp_count got=%0d required=%0d", a_frame_count, a_exp_count);
    end
  endtask

  task automatic test_lingering_ack();
    logic [63:0] v;
    for (int i = 0; i < 8; i++) a_sent[i] = 8'($urandom);
    v = a_model_vec();
    a_fill(1'b0);
    a_serve(1, 1'b1, 1'b0, '0);
    a_exp_vec = v;
    a_drain(8, -1, 0);
    a_exp_count++;
    checks++;
    if (a_got.size() != 8 || a_got[7] !== v[63:56]) begin
      failures++;
      $display("FAIL linger_frame1 beats=%0d last=%h required=8/%h", a_got.size(),
               (a_got.size() == 8) ? a_got[7] : 8'hxx, v[63:56]);
    end
    for (int i = 0; i < 8; i++) a_sent[i] = 8'($urandom);
    v = a_model_vec();
    a_fill(1'b0);
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (a_state !== ST_WAITLOW || a_net_req !== 1'b0) begin
        failures++;
        $display("FAIL linger_wait%0d state=%0d req=%b required=%0d/0", c, a_state, a_net_req, ST_WAITLOW);
      end
      step();
    end
    a_net_ack = 1'b0;
    step();
    checks++;
    if (a_state !== ST_RUN || a_net_req !== 1'b0) begin
      failures++;
      $display("FAIL linger_run_entry state=%0d req=%b required=%0d/0", a_state, a_net_req, ST_RUN);
    end
    step();
    checks++;
    if (a_net_req !== 1'b1) begin
      failures++;
      $display("FAIL linger_req_rise req=%b required=1", a_net_req);
    end
    a_serve(2, 1'b0, 1'b0, '0);
    a_exp_vec = v;
    a_drain(8, -1, 0);
    a_exp_count++;
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (a_got.size() <= k || a_got[k] !== v[k*8 +: 8]) begin
        failures++;
        $display("FAIL linger_beat%0d got=%h required=%h", k, (a_got.size() > k) ? a_got[k] : 8'hxx, v[k*8 +: 8]);
      end
    end
  endtask

  task automatic test_abort();
    int guard = 0;
    int done_before;
    logic [63:0] v;
    for (int i = 0; i < 8; i++) a_sent[i] = 8'($urandom);
    a_fill(1'b0);
    while (a_net_req !== 1'b1 && guard < 50) begin
      step();
      guard++;
    end
    checks++;
    if (a_net_req !== 1'b1) begin
      failures++;
      $display("FAIL abort_wait_req req=%b required=1", a_net_req);
    end
    done_before = a_done_cnt;
    a_res_bus = {$urandom, $urandom};
    a_net_ack = 1'b1;
    a_clr     = 1'b1;
    step();
    a_clr     = 1'b0;
    a_net_ack = 1'b0;
    checks++;
    if (a_fill_ready !== 1'b1 || a_busy !== 1'b0 || a_out_valid !== 1'b0 || a_net_req !== 1'b0) begin
      failures++;
      $display("FAIL abort_state rdy=%b busy=%b val=%b req=%b required=1/0/0/0",
               a_fill_ready, a_busy, a_out_valid, a_net_req);
    end
    checks++;
    if (a_out_vec !== a_exp_vec || a_frame_count !== 16'(a_exp_count)) begin
      failures++;
      $display("FAIL abort_kept vec=%h cnt=%0d required=%h/%0d", a_out_vec, a_frame_count, a_exp_vec, a_exp_count);
    end
    step();
    checks++;
    if (a_done_cnt != done_before) begin
      failures++;
      $display("FAIL abort_no_done pulses=%0d required=0", a_done_cnt - done_before);
    end
    for (int i = 0; i < 8; i++) a_sent[i] = 8'($urandom);
    v = a_model_vec();
    a_fill(1'b0);
    a_serve(1, 1'b0, 1'b0, '0);
    a_exp_vec = v;
    a_drain(8, -1, 0);
    a_exp_count++;
    checks++;
    if (a_got.size() != 8 || a_got[0] !== v[7:0] || a_got[7] !== v[63:56] ||
        a_frame_count !== 16'(a_exp_count)) begin
      failures++;
      $display("FAIL abort_next_frame beats=%0d cnt=%0d required=8/%0d", a_got.size(), a_frame_count, a_exp_count);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] v;
    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < 8; i++) a_sent[i] = 8'($urandom);
      v = a_model_vec();
      a_fill(1'($urandom_range(0, 1)));
      a_serve($urandom_range(0, 5), 1'b0, 1'b0, '0);
      a_exp_vec = v;
      checks++;
      if (a_out_vec !== v) begin
        failures++;
        $display("FAIL b2b_vec%0d got=%h required=%h", f, a_out_vec, v);
      end
      a_drain(8, $urandom_range(0, 7), $urandom_range(0, 3));
      a_exp_count++;
      for (int k = 0; k < 8; k++) begin
        checks++;
        if (a_got.size() <= k || a_got[k] !== v[k*8 +: 8]) begin
          failures++;
          $display("FAIL b2b_f%0d_beat%0d got=%h required=%h", f, k,
                   (a_got.size() > k) ? a_got[k] : 8'hxx, v[k*8 +: 8]);
        end
      end
    end
    checks++;
    if (a_frame_count !== 16'(a_exp_count)) begin
      failures++;
      $display("FAIL b2b_count got=%0d required=%0d", a_frame_count, a_exp_count);
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 8; i++) a_sent[i] = 8'($urandom);
    a_fill(1'b0);
    a_serve(0, 1'b0, 1'b0, '0);
    a_out_ready = 1'b1;
    repeat (3) step();
    a_out_ready = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (a_out_valid !== 1'b0 || a_frame_count !== 16'd0 || a_busy !== 1'b0 ||
        a_net_req !== 1'b0 || a_out_vec !== 64'd0) begin
      failures++;
      $display("FAIL async_reset val=%b cnt=%0d busy=%b req=%b vec=%h required=0/0/0/0/0",
               a_out_valid, a_frame_count, a_busy, a_net_req, a_out_vec);
    end
    #3;
    rst = 1'b1;
    step();
    a_exp_count = 0;
    a_exp_vec   = '0;
  endtask

  task automatic test_param_sweep();
    logic [11:0] s [5];
    logic [35:0] r;
    logic [11:0] got [$];
    int exp_cnt = 0;
    int guard;
    for (int f = 0; f < 5; f++) begin
      for (int i = 0; i < 5; i++) begin
        s[i] = 12'($urandom);
        b_fill_valid = 1'b1;
        b_fill_data  = s[i];
        step();
      end
      b_fill_valid = 1'b0;
      guard = 0;
      while (b_net_req !== 1'b1 && guard < 50) begin
        step();
        guard++;
      end
      r = 36'({$urandom, $urandom});
      b_res_bus = r;
      b_net_ack = 1'b1;
      step();
      b_net_ack = 1'b0;
      got.delete();
      guard = 0;
      b_out_ready = 1'b1;
      while (got.size() < 3 && guard < 50) begin
        if (b_out_valid) got.push_back(b_out_data);
        step();
        guard++;
      end
      b_out_ready = 1'b0;
      exp_cnt = (exp_cnt + 1) % 4;
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (got.size() <= k || got[k] !== r[k*12 +: 12]) begin
          failures++;
          $display("FAIL sweep_f%0d_beat%0d got=%h required=%h", f, k,
                   (got.size() > k) ? got[k] : 12'hxxx, r[k*12 +: 12]);
        end
      end
      checks++;
      if (b_frame_count !== 2'(exp_cnt)) begin
        failures++;
        $display("FAIL sweep_count_f%0d got=%0d required=%0d", f, b_frame_count, exp_cnt);
      end
    end
    b_rd_addr = 3'd7;
    step();
    checks++;
    if (b_rd_data !== 12'd0) begin
      failures++;
      $display("FAIL sweep_rd_oob got=%h required=000", b_rd_data);
    end
    b_rd_addr = 3'd4;
    step();
    checks++;
    if (b_rd_data !== s[4]) begin
      failures++;
      $display("FAIL sweep_rd_addr4 got=%h required=%h", b_rd_data, s[4]);
    end
  endtask

  initial begin
    a_clr = 0; a_fill_valid = 0; a_fill_data = 0; a_net_ack = 0; a_rd_addr = 0;
    a_res_bus = 0; a_out_ready = 0;
    b_clr = 0; b_fill_valid = 0; b_fill_data = 0; b_net_ack = 0; b_rd_addr = 0;
    b_res_bus = 0; b_out_ready = 0;
    test_reset();
    test_basic();
    test_backpressure();
    test_lingering_ack();
    test_abort();
    test_back_to_back();
    test_async_reset();
    test_param_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
